// File: rtl/cdp_rdma_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cdp_rdma_rd_arb
//  Purpose  : Two-requester round-robin read-request arbiter with
//             per-requester credit limiting and a registered output stage.
//             Shares one MCIF read-request channel between requester 0
//             (feature-data fetch) and requester 1 (auxiliary/table fetch).
//  Ports    :
//    nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//    op_en                            : arbitration enable (0 blocks grants)
//    r0_req_* / r1_req_*              : requester valid/ready/payload
//    cdt_pop[1:0]                     : credit return pulse per requester
//    mc_req_valid/ready/pd            : merged request towards MCIF
//    mc_req_src                       : requester id of current mc_req_pd
//    cdt_err                          : sticky credit-overflow flag
//    r0_stall_cnt / r1_stall_cnt      : stall counters (CDP_RDMA_ARB_PERF_EN)
//  Config   : define CDP_RDMA_ARB_PERF_EN to build the stall counters;
//             otherwise they read as zero and no counter flops exist.
//  Revision : 1.0 - initial release
// ============================================================================
module cdp_rdma_rd_arb #(
    parameter int PD_W       = 47,
    parameter int CREDIT_NUM = 8,
    parameter int CNT_W      = 4
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            op_en,
    input  logic            r0_req_valid,
    output logic            r0_req_ready,
    input  logic [PD_W-1:0] r0_req_pd,
    input  logic            r1_req_valid,
    output logic            r1_req_ready,
    input  logic [PD_W-1:0] r1_req_pd,
    input  logic [1:0]      cdt_pop,
    output logic            mc_req_valid,
    input  logic            mc_req_ready,
    output logic [PD_W-1:0] mc_req_pd,
    output logic            mc_req_src,
    output logic            cdt_err,
    output logic [31:0]     r0_stall_cnt,
    output logic [31:0]     r1_stall_cnt
);

    localparam logic [CNT_W-1:0] C_CREDIT_MAX = CNT_W'(CREDIT_NUM);

    logic                   r_mc_valid;
    logic [PD_W-1:0]        r_mc_pd;
    logic                   r_mc_src;
    logic                   r_rr_last;
    logic                   r_cdt_err;
    logic [1:0][CNT_W-1:0]  r_credit;
    logic [1:0][CNT_W-1:0]  w_credit_nxt;

    logic                   w_slot_free;
    logic [1:0]             w_req_valid;
    logic [1:0]             w_elig;
    logic [1:0]             w_grant;
    logic [1:0]             w_sat;

    // The output register can take a new request when empty or draining.
    assign w_slot_free = ~r_mc_valid | mc_req_ready;
    assign w_req_valid = {r1_req_valid, r0_req_valid};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign w_elig[gi] = w_req_valid[gi] & (r_credit[gi] != '0) & op_en & w_slot_free;

            // A return that would push the counter past its maximum is an
            // accounting error upstream; the counter saturates instead.
            assign w_sat[gi] = cdt_pop[gi] & ~w_grant[gi] & (r_credit[gi] == C_CREDIT_MAX);

            always_comb begin
                w_credit_nxt[gi] = r_credit[gi];
                if (cdt_pop[gi] & ~w_grant[gi]) begin
                    if (!w_sat[gi]) begin
                        w_credit_nxt[gi] = r_credit[gi] + CNT_W'(1);
                    end
                end else if (~cdt_pop[gi] & w_grant[gi]) begin
                    w_credit_nxt[gi] = r_credit[gi] - CNT_W'(1);
                end
            end
        end
    endgenerate

    // rr_last names the most recent winner; on a contest the other one wins.
    assign w_grant[0] = w_elig[0] & (~w_elig[1] | r_rr_last);
    assign w_grant[1] = w_elig[1] & (~w_elig[0] | ~r_rr_last);

    assign r0_req_ready = w_grant[0];
    assign r1_req_ready = w_grant[1];

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_credit <= {C_CREDIT_MAX, C_CREDIT_MAX};
            r_cdt_err <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            if (|w_sat) begin
                r_cdt_err <= 1'b1;
            end
        end
    end

    // Registered output stage: payload and source only change on a grant,
    // so they stay stable while the downstream back-pressures.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_mc_valid <= 1'b0;
            r_mc_pd    <= '0;
            r_mc_src   <= 1'b0;
            r_rr_last  <= 1'b1;
        end else if (|w_grant) begin
            r_mc_valid <= 1'b1;
            r_mc_pd    <= w_grant[0] ? r0_req_pd : r1_req_pd;
            r_mc_src   <= w_grant[1];
            r_rr_last  <= w_grant[1];
        end else if (w_slot_free) begin
            r_mc_valid <= 1'b0;
        end
    end

    assign mc_req_valid = r_mc_valid;
    assign mc_req_pd    = r_mc_pd;
    assign mc_req_src   = r_mc_src;
    assign cdt_err      = r_cdt_err;

`ifdef CDP_RDMA_ARB_PERF_EN
    logic        r_op_en_d;
    logic [31:0] r_stall_cnt0;
    logic [31:0] r_stall_cnt1;

    // Counters restart at each new operation (op_en rising edge) and
    // saturate rather than wrap.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_op_en_d    <= 1'b0;
            r_stall_cnt0 <= '0;
            r_stall_cnt1 <= '0;
        end else begin
            r_op_en_d <= op_en;
            if (op_en & ~r_op_en_d) begin
                r_stall_cnt0 <= '0;
                r_stall_cnt1 <= '0;
            end else begin
                if (r0_req_valid & ~w_grant[0] & ~(&r_stall_cnt0)) begin
                    r_stall_cnt0 <= r_stall_cnt0 + 32'd1;
                end
                if (r1_req_valid & ~w_grant[1] & ~(&r_stall_cnt1)) begin
                    r_stall_cnt1 <= r_stall_cnt1 + 32'd1;
                end
            end
        end
    end

    assign r0_stall_cnt = r_stall_cnt0;
    assign r1_stall_cnt = r_stall_cnt1;
`else
    assign r0_stall_cnt = 32'd0;
    assign r1_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
